// File: rtl/alb_pkg.sv
// Shared definitions for the 10-bit ALU and its multi-word chaining sequencer.
package alb_pkg;

    localparam int ALB_W = 10;

    // ALU function select codes
    localparam logic [1:0] OP_NOR_OR = 2'b00;  // F = ~R | S
    localparam logic [1:0] OP_ADD    = 2'b01;  // F = R + S + CI
    localparam logic [1:0] OP_XNOR   = 2'b10;  // F = ~(R ^ S)
    localparam logic [1:0] OP_SUB    = 2'b11;  // F = R - S, CI=1 means no borrow in

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        OUT
    } state_t;

endpackage

// File: rtl/alb.sv
// Combinational 10-bit ALU. For subtract, CO=1 signals a borrow out.
module alb
    import alb_pkg::*;
(
    input  logic [ALB_W-1:0] r,
    input  logic [ALB_W-1:0] s,
    input  logic             ci,
    input  logic [1:0]       sel,
    output logic [ALB_W-1:0] f,
    output logic             co,
    output logic             vo,
    output logic             no,
    output logic             zo
);

    logic [ALB_W:0] sum;

    // Function select, carry/borrow and signed overflow
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        sum = '0;
        f   = '0;
        co  = 1'b0;
        vo  = 1'b0;
        case (sel)
            OP_ADD: begin
                sum = {1'b0, r} + {1'b0, s} + {{ALB_W{1'b0}}, ci};
                f   = sum[ALB_W-1:0];
                co  = sum[ALB_W];
                vo  = (r[ALB_W-1] == s[ALB_W-1]) && (f[ALB_W-1] != r[ALB_W-1]);
            end
            OP_SUB: begin
                sum = {1'b0, r} + {1'b0, ~s} + {{ALB_W{1'b0}}, ci};
                f   = sum[ALB_W-1:0];
                co  = ~sum[ALB_W];
                vo  = (r[ALB_W-1] != s[ALB_W-1]) && (f[ALB_W-1] != r[ALB_W-1]);
            end
            OP_NOR_OR: f = ~r | s;
            default:   f = ~(r ^ s);
        endcase
        no = f[ALB_W-1];
        zo = (f == '0);
    end

endmodule

// File: rtl/alb_chain_ctrl.sv
// Multi-word sequencer around the ALU: streams operand words LSW-first,
// chains carry/borrow between words and returns each result word with flags.
module alb_chain_ctrl
    import alb_pkg::*;
#(
    parameter int WIDTH     = ALB_W,
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W:0]   nwords,
    input  logic             ci_init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_s,
    output logic [WIDTH-1:0] alu_r,
    output logic [WIDTH-1:0] alu_s,
    output logic             alu_ci,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_co,
    input  logic             alu_vo,
    input  logic             alu_no,
    input  logic             alu_zo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_last,
    output logic             co_o,
    output logic             vo_o,
    output logic             no_o,
    output logic             zo_o,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_idx_q, last_idx_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic [WIDTH-1:0] alu_r_q, alu_r_d, alu_s_q, alu_s_d, out_f_q, out_f_d;
    logic             alu_ci_q, alu_ci_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic             out_last_q, out_last_d, out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             co_q, co_d, vo_q, vo_d, no_q, no_d, zo_q, zo_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CNT_W:0]   nw_eff;
    logic             is_last;

    // Effective word count: 0 behaves as 1, oversize requests clamp to MAX_WORDS
    always_comb begin
        if (nwords == '0)
            nw_eff = (CNT_W+1)'(1);
        else if (nwords > (CNT_W+1)'(MAX_WORDS))
            nw_eff = (CNT_W+1)'(MAX_WORDS);
        else
            nw_eff = nwords;
    end

    assign is_last = (cnt_q == last_idx_q);

    // Next-state and next-output logic for the IDLE/LOAD/EXEC/OUT sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_idx_d  = last_idx_q;
        carry_d     = carry_q;
        zacc_d      = zacc_q;
        alu_r_d     = alu_r_q;
        alu_s_d     = alu_s_q;
        alu_ci_d    = alu_ci_q;
        alu_sel_d   = alu_sel_q;
        out_f_d     = out_f_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        co_d        = co_q;
        vo_d        = vo_q;
        no_d        = no_q;
        zo_d        = zo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    alu_sel_d  = op;
                    last_idx_d = CNT_W'(nw_eff - (CNT_W+1)'(1));
                    carry_d    = ci_init;
                    zacc_d     = 1'b1;
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    alu_r_d    = in_r;
                    alu_s_d    = in_s;
                    alu_ci_d   = carry_q;
                    in_ready_d = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                out_f_d = alu_f;
                zacc_d  = zacc_q & alu_zo;
                // Subtract chains the inverse of CO because CO=1 means borrow;
                // logic ops keep the carry register at ci_init.
                case (alu_sel_q)
                    OP_ADD:  carry_d = alu_co;
                    OP_SUB:  carry_d = ~alu_co;
                    default: carry_d = carry_q;
                endcase
                if (is_last) begin
                    // CO is meaningless for logic ops, so arithmetic flags are forced low
                    co_d = (alu_sel_q == OP_ADD || alu_sel_q == OP_SUB) ? alu_co : 1'b0;
                    vo_d = (alu_sel_q == OP_ADD || alu_sel_q == OP_SUB) ? alu_vo : 1'b0;
                    no_d = alu_no;
                    zo_d = zacc_q & alu_zo;
                end
                out_last_d  = is_last;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        in_ready_d = 1'b1;
                        state_d    = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset returns everything to zero/IDLE at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_idx_q  <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            alu_r_q     <= '0;
            alu_s_q     <= '0;
            alu_ci_q    <= 1'b0;
            alu_sel_q   <= '0;
            out_f_q     <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            co_q        <= 1'b0;
            vo_q        <= 1'b0;
            no_q        <= 1'b0;
            zo_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_idx_q  <= last_idx_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            alu_r_q     <= alu_r_d;
            alu_s_q     <= alu_s_d;
            alu_ci_q    <= alu_ci_d;
            alu_sel_q   <= alu_sel_d;
            out_f_q     <= out_f_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            co_q        <= co_d;
            vo_q        <= vo_d;
            no_q        <= no_d;
            zo_q        <= zo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign alu_r     = alu_r_q;
    assign alu_s     = alu_s_q;
    assign alu_ci    = alu_ci_q;
    assign alu_sel   = alu_sel_q;
    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign out_last  = out_last_q;
    assign co_o      = co_q;
    assign vo_o      = vo_q;
    assign no_o      = no_q;
    assign zo_o      = zo_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alb_chain_ctrl.sv
// Directed bench: sequencer wired to the ALU, expected values worked out by hand.
module tb_alb_chain_ctrl;
    import alb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, ci_init, in_valid, out_ready;
    logic [1:0] op;
    logic [2:0] nwords;
    logic [9:0] in_r, in_s;
    logic       in_ready, out_valid, out_last, co_o, vo_o, no_o, zo_o, busy, done;
    logic [9:0] out_f;
    logic [9:0] alu_r, alu_s, alu_f;
    logic       alu_ci, alu_co, alu_vo, alu_no, alu_zo;
    logic [1:0] alu_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alb_chain_ctrl #(.WIDTH(10), .MAX_WORDS(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .nwords(nwords),
        .ci_init(ci_init), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_s(in_s), .alu_r(alu_r), .alu_s(alu_s),
        .alu_ci(alu_ci), .alu_sel(alu_sel), .alu_f(alu_f), .alu_co(alu_co),
        .alu_vo(alu_vo), .alu_no(alu_no), .alu_zo(alu_zo),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
        .out_last(out_last), .co_o(co_o), .vo_o(vo_o), .no_o(no_o),
        .zo_o(zo_o), .busy(busy), .done(done)
    );

    alb u_alb (
        .r(alu_r), .s(alu_s), .ci(alu_ci), .sel(alu_sel),
        .f(alu_f), .co(alu_co), .vo(alu_vo), .no(alu_no), .zo(alu_zo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [2:0] n, input logic c);
        op = o; nwords = n; ci_init = c; start = 1'b1;
        tick();
        start = 1'b0;
        // scramble the operation inputs: they must be ignored from here on
        op = ~o; nwords = 3'd0; ci_init = ~c;
    endtask

    task automatic send_word(input string tag, input logic [9:0] r, input logic [9:0] s);
        int n = 0;
        in_r = r; in_s = s; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " out_valid"}, out_valid, 1'b1);
    endtask

    task automatic recv(input string tag, input logic [9:0] exp_f, input logic exp_last);
        wait_out(tag);
        check({tag, " f"}, out_f, exp_f);
        check({tag, " last"}, out_last, exp_last);
        check({tag, " in_ready low"}, in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_done(input string tag);
        check({tag, " done"}, done, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        tick();
        check({tag, " done pulse"}, done, 1'b0);
    endtask

    task automatic check_flags(input string tag, input logic co, input logic vo,
                               input logic no, input logic zo);
        check({tag, " co"}, co_o, co);
        check({tag, " vo"}, vo_o, vo);
        check({tag, " no"}, no_o, no);
        check({tag, " zo"}, zo_o, zo);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'b00; nwords = 3'd0; ci_init = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_r = '0; in_s = '0;
        #1 rst = 1'b1;
        #2;
        check("rst busy", busy, 1'b0);
        check("rst in_ready", in_ready, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst done", done, 1'b0);
        check("rst out_f", out_f, 10'h000);
        check("rst alu_sel", alu_sel, 2'b00);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 1: two-word add, carry chains from word 0 into word 1
        start_op(OP_ADD, 3'd2, 1'b0);
        check("add busy", busy, 1'b1);
        check("add in_ready", in_ready, 1'b1);
        check("add alu_sel", alu_sel, OP_ADD);
        send_word("add w0", 10'h3FF, 10'h001);
        check("add w0 alu_r", alu_r, 10'h3FF);
        check("add w0 alu_ci", alu_ci, 1'b0);
        check("add w0 exec not valid", out_valid, 1'b0);
        tick();
        check("add w0 latency", out_valid, 1'b1);
        recv("add w0", 10'h000, 1'b0);
        send_word("add w1", 10'h3FF, 10'h000);
        check("add w1 alu_ci", alu_ci, 1'b1);
        recv("add w1", 10'h000, 1'b1);
        check_flags("add", 1'b1, 1'b0, 1'b0, 1'b1);
        check_done("add");

        // 2: two-word subtract, borrow from word 0 clears word-1 carry-in
        start_op(OP_SUB, 3'd2, 1'b1);
        send_word("sub w0", 10'h000, 10'h001);
        check("sub w0 alu_ci", alu_ci, 1'b1);
        recv("sub w0", 10'h3FF, 1'b0);
        check("sub prev co held", co_o, 1'b1);
        check("sub prev zo held", zo_o, 1'b1);
        send_word("sub w1", 10'h001, 10'h000);
        check("sub w1 alu_ci", alu_ci, 1'b0);
        recv("sub w1", 10'h000, 1'b1);
        check_flags("sub", 1'b0, 1'b0, 1'b0, 1'b0);
        check_done("sub");

        // 3: single-word ~R|S
        start_op(OP_NOR_OR, 3'd1, 1'b0);
        send_word("nor", 10'h0F0, 10'h000);
        recv("nor", 10'h30F, 1'b1);
        check_flags("nor", 1'b0, 1'b0, 1'b1, 1'b0);
        check_done("nor");

        // 4: output backpressure, 5+3+ci(1)=9
        start_op(OP_ADD, 3'd1, 1'b1);
        send_word("bp", 10'h005, 10'h003);
        wait_out("bp");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp valid held", out_valid, 1'b1);
            check("bp f held", out_f, 10'h009);
            check("bp in_ready", in_ready, 1'b0);
            check("bp busy", busy, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_flags("bp", 1'b0, 1'b0, 1'b0, 1'b0);
        check_done("bp");

        // 5: nwords=0 acts as one word; stray start while busy is ignored
        start_op(OP_XNOR, 3'd0, 1'b0);
        op = OP_ADD; nwords = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("xnor stray start in_ready", in_ready, 1'b1);
        check("xnor stray start sel", alu_sel, OP_XNOR);
        send_word("xnor", 10'h155, 10'h155);
        recv("xnor", 10'h3FF, 1'b1);
        check_flags("xnor", 1'b0, 1'b0, 1'b1, 1'b0);
        check_done("xnor");
        check("xnor no restart", busy, 1'b0);

        // 5b: nwords above MAX_WORDS clamps to 4 words
        start_op(OP_XNOR, 3'd7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_word("clamp", 10'(i), 10'(i + 1));
            recv("clamp", ~(10'(i) ^ 10'(i + 1)), (i == 3));
        end
        check_done("clamp");

        // 6: reset during EXEC of word 1 of 3
        start_op(OP_ADD, 3'd3, 1'b0);
        send_word("rst w0", 10'h001, 10'h001);
        recv("rst w0", 10'h002, 1'b0);
        send_word("rst w1", 10'h010, 10'h020);
        check("rst exec in_ready", in_ready, 1'b0);
        check("rst exec out_valid", out_valid, 1'b0);
        rst = 1'b1;
        #1;
        check("mid rst busy", busy, 1'b0);
        check("mid rst in_ready", in_ready, 1'b0);
        check("mid rst alu_r", alu_r, 10'h000);
        check("mid rst alu_s", alu_s, 10'h000);
        check("mid rst alu_sel", alu_sel, 2'b00);
        check("mid rst out_f", out_f, 10'h000);
        check_flags("mid rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post rst no done", done, 1'b0);
            check("post rst out_valid", out_valid, 1'b0);
        end
        start_op(OP_ADD, 3'd1, 1'b0);
        send_word("post rst add", 10'h001, 10'h002);
        recv("post rst add", 10'h003, 1'b1);
        check_flags("post rst add", 1'b0, 1'b0, 1'b0, 1'b0);
        check_done("post rst add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
